delay_sched: RTL and testbench

Round-robin scheduler that shares a single programmable delay counter among `NREQ` requesters. Each requester asks for a timeout of up to `N` cycles. The block grants the counter to one requester at a time, runs the countdown, and pulses that requester's `done` line on expiry. It sits in front of the delay/timeout datapath so that multiple control FSMs can reuse one counter instead of instantiating their own.

---
 rtl/delay_sched_pkg.sv | 23 ++
 rtl/delay_sched_rr_pick.sv | 36 +++
 rtl/delay_sched.sv | 134 +++++++++++++
 tb/tb_delay_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay_sched round-robin delay-counter scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_N     = 15000;
  localparam int DEF_CBITS = 14;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick
  import delay_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx,
  output logic [NREQ-1:0] sel
);

  localparam int JW = PW + 1;

  logic [JW-1:0] j;

  // Walk candidates from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + JW'(k);
      if (j >= JW'(NREQ)) j = j - JW'(NREQ);
      if (req[j[PW-1:0]]) begin
        sel = '0;
        sel[j[PW-1:0]] = 1'b1;
      end
    end
  end

  assign any = |req;
  assign idx = PW'(onehot_to_idx(8'(sel)));

endmodule

// File: rtl/delay_sched.sv
// Shares one programmable delay counter among NREQ requesters with round-robin
// grant; pulses the owner's done line when its (clamped) delay expires.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CBITS = DEF_CBITS,
  parameter  int N     = DEF_N,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] dly,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err,
  output state_t                dbg_state,
  output logic [PW-1:0]         dbg_ptr
);

  localparam logic [CBITS-1:0] NMAX = CBITS'(N);

  state_t            state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [CBITS-1:0]  tgt_q, tgt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              pick_any;
  logic [PW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_sel;
  logic [CBITS-1:0]  pick_dly;
  logic              pick_over;
  logic [PW-1:0]     next_ptr;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx),
    .sel (pick_sel)
  );

  always_comb begin
    pick_dly = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel[i]) pick_dly = dly[i*CBITS +: CBITS];
    end
  end

  assign pick_over = (pick_dly > NMAX);
  assign next_ptr  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          tgt_d   = pick_over ? NMAX : pick_dly;
          gnt_d   = pick_sel;
          err_d   = pick_over;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A dropped request aborts even if the count expires this same cycle.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (cnt_q == tgt_q) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      DONE: begin
        ptr_d   = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: a transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_delay_sched;
  import delay_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int CBITS = 14;
  localparam int N     = 15000;
  localparam int PW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*CBITS-1:0] dly = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy, err;
  state_t                dbg_state;
  logic [PW-1:0]         dbg_ptr;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int t0;

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dly       (dly),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecount, got, exp);
    end
  endtask

  // ---------------- timing model ----------------
  // Edge labels: the model's edge e is the posedge after which ecount reads e+1.
  // A grant sampled at edge t0 with delay D expires at edge t0+1+D; the block
  // may sample a new request two edges later, or one edge after an abort.
  int              m_owner     = -1;
  int              m_exp_edge  = 0;
  int              m_idle_edge = 0;
  int              m_ptr       = 0;
  int              m_ptr_pend  = 0;
  logic [NREQ-1:0] e_gnt  = '0;
  logic [NREQ-1:0] e_done = '0;
  logic            e_busy = 1'b0;
  logic            e_err  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner     = -1;
      m_ptr       = 0;
      m_ptr_pend  = 0;
      m_idle_edge = 0;
      e_gnt = '0; e_done = '0; e_busy = 1'b0; e_err = 1'b0;
    end else begin
      e_done = '0;
      e_err  = 1'b0;
      if (m_owner < 0) begin
        if (ecount < m_idle_edge) begin
          e_busy = 1'b0;
          m_ptr  = m_ptr_pend;
        end else if (req != '0) begin
          int o, d;
          o = -1;
          for (int k = NREQ - 1; k >= 0; k--)
            if (req[(m_ptr + k) % NREQ]) o = (m_ptr + k) % NREQ;
          d = int'(dly[o*CBITS +: CBITS]);
          e_err = (d > N);
          if (d > N) d = N;
          m_owner    = o;
          m_exp_edge = ecount + 1 + d;
          e_gnt      = 4'b0001 << o;
          e_busy     = 1'b1;
        end
      end else if (!req[m_owner]) begin
        e_gnt       = '0;
        e_busy      = 1'b0;
        m_ptr       = (m_owner + 1) % NREQ;
        m_owner     = -1;
        m_idle_edge = ecount + 1;
      end else if (ecount == m_exp_edge) begin
        e_gnt       = '0;
        e_done      = 4'b0001 << m_owner;
        m_ptr_pend  = (m_owner + 1) % NREQ;
        m_owner     = -1;
        m_idle_edge = ecount + 2;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_gnt",  32'(gnt),     32'(e_gnt));
      chk("model_done", 32'(done),    32'(e_done));
      chk("model_busy", 32'(busy),    32'(e_busy));
      chk("model_err",  32'(err),     32'(e_err));
      chk("model_ptr",  32'(dbg_ptr), 32'(m_ptr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [NREQ-1:0] r);
    @(posedge clk);
    #3;
    req = r;
  endtask

  task automatic set_dly(input int i, input logic [CBITS-1:0] v);
    dly[i*CBITS +: CBITS] = v;
  endtask

  // Land on the negedge inside cycle c (the cycle after edge label c-1).
  task automatic at_cycle(input int c);
    @(negedge clk);
    while (ecount < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1;
    chk("reset_gnt",   32'(gnt),       32'h0);
    chk("reset_done",  32'(done),      32'h0);
    chk("reset_busy",  32'(busy),      32'h0);
    chk("reset_err",   32'(err),       32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_ptr",   32'(dbg_ptr),   32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Single requester, delay 5.
    set_dly(0, 14'd5);
    set_req(4'b0001);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t1_gnt", 32'(gnt), 32'h1); chk("t1_busy", 32'(busy), 32'h1);
    at_cycle(t0 + 6); chk("t1_done_early", 32'(done), 32'h0);
    at_cycle(t0 + 7); chk("t1_done", 32'(done), 32'h1); chk("t1_gnt_fall", 32'(gnt), 32'h0);
    set_req(4'b0000);
    at_cycle(t0 + 8); chk("t1_busy_low", 32'(busy), 32'h0); chk("t1_done_end", 32'(done), 32'h0);

    // Two requesters, all delays 2, pointer back at 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_dly(i, 14'd2);
    set_req(4'b0101);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t2_gnt0", 32'(gnt), 32'h1);
    at_cycle(t0 + 4); chk("t2_done0", 32'(done), 32'h1);
    set_req(4'b0100);
    at_cycle(t0 + 6); chk("t2_gnt2", 32'(gnt), 32'h4);
    at_cycle(t0 + 9); chk("t2_done2", 32'(done), 32'h4);
    set_req(4'b0000);
    at_cycle(t0 + 10); chk("t2_ptr", 32'(dbg_ptr), 32'h3);

    // Over-range delay (largest 14-bit value) clamps to N.
    set_dly(1, 14'd16383);
    set_req(4'b0010);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t3_err", 32'(err), 32'h1); chk("t3_gnt", 32'(gnt), 32'h2);
    at_cycle(t0 + 2); chk("t3_err_pulse", 32'(err), 32'h0);
    at_cycle(t0 + 15001); chk("t3_done_early", 32'(done), 32'h0);
    at_cycle(t0 + 15002); chk("t3_done", 32'(done), 32'h2);
    set_req(4'b0000);
    at_cycle(t0 + 15003); chk("t3_ptr", 32'(dbg_ptr), 32'h2);

    // Delay exactly N: no error, full-length count.
    set_dly(0, 14'(N));
    set_req(4'b0001);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t3b_err", 32'(err), 32'h0);
    at_cycle(t0 + 15002); chk("t3b_done", 32'(done), 32'h1);
    set_req(4'b0000);
    at_cycle(t0 + 15003); chk("t3b_ptr", 32'(dbg_ptr), 32'h1);

    // Abort of requester 3 on the tenth count cycle.
    set_dly(3, 14'd100);
    set_req(4'b1000);
    t0 = ecount;
    at_cycle(t0 + 9); chk("t4_gnt", 32'(gnt), 32'h8);
    set_req(4'b0000);
    at_cycle(t0 + 10); chk("t4_gnt_held", 32'(gnt), 32'h8);
    at_cycle(t0 + 11);
    chk("t4_gnt_off", 32'(gnt), 32'h0);
    chk("t4_busy_off", 32'(busy), 32'h0);
    chk("t4_ptr", 32'(dbg_ptr), 32'h0);
    chk("t4_no_done", 32'(done), 32'h0);

    // Asynchronous reset in the middle of a count.
    set_dly(2, 14'd50);
    set_req(4'b0100);
    t0 = ecount;
    at_cycle(t0 + 5); chk("t5_gnt", 32'(gnt), 32'h4);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("t5_rst_gnt",   32'(gnt),       32'h0);
    chk("t5_rst_busy",  32'(busy),      32'h0);
    chk("t5_rst_done",  32'(done),      32'h0);
    chk("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    set_dly(1, 14'd3);
    set_req(4'b1010);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t5_regrant", 32'(gnt), 32'h2);
    at_cycle(t0 + 5); chk("t5_done1", 32'(done), 32'h2);
    set_req(4'b0000);
    at_cycle(t0 + 6); chk("t5_ptr", 32'(dbg_ptr), 32'h2);

    // Zero delay on the last requester; pointer wraps.
    set_dly(3, 14'd0);
    set_req(4'b1000);
    t0 = ecount;
    at_cycle(t0 + 1); chk("t6_gnt", 32'(gnt), 32'h8);
    at_cycle(t0 + 2); chk("t6_done", 32'(done), 32'h8); chk("t6_gnt_fall", 32'(gnt), 32'h0);
    set_req(4'b0000);
    at_cycle(t0 + 3); chk("t6_ptr_wrap", 32'(dbg_ptr), 32'h0); chk("t6_busy", 32'(busy), 32'h0);

    // All four requesting continuously: rotation checked by the model.
    set_dly(0, 14'd1);
    set_dly(1, 14'd0);
    set_dly(2, 14'd3);
    set_dly(3, 14'd2);
    set_req(4'b1111);
    repeat (40) @(negedge clk);
    set_req(4'b0110);
    repeat (20) @(negedge clk);
    set_req(4'b0000);
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
